// File: rtl/piso_serializer.sv
// Parallel-in, serial-out stage: accepts words over valid/ready and emits them LSB first,
// one bit per clock, with a one-deep holding buffer and optional idle gap between words.
module piso_serializer #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GapLast = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic [WIDTH-1:0] hbuf_q, hbuf_d;
    logic             hvalid_q, hvalid_d;
    logic             accept;

    assign din_ready = ~hvalid_q & ~clear;
    assign accept    = din_valid & din_ready;

    // Outputs depend only on registered state, so din never reaches so combinationally.
    assign so_valid  = (state_q == StShift);
    assign so        = (state_q == StShift) & sreg_q[0];
    assign word_done = (state_q == StShift) && (cnt_q == CntLast);
    assign busy      = (state_q != StIdle) | hvalid_q;

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        gcnt_d   = gcnt_q;
        hbuf_d   = hbuf_q;
        hvalid_d = hvalid_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sreg_d  = din;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end

            StShift: begin
                sreg_d = sreg_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                        gcnt_d  = '0;
                        if (accept) begin
                            hbuf_d   = din;
                            hvalid_d = 1'b1;
                        end
                    end else if (hvalid_q) begin
                        sreg_d   = hbuf_q;
                        hvalid_d = 1'b0;
                    end else if (accept) begin
                        // Bypass the buffer so the next word follows with no bubble.
                        sreg_d = din;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (accept) begin
                    hbuf_d   = din;
                    hvalid_d = 1'b1;
                end
            end

            StGap: begin
                gcnt_d = gcnt_q + 1'b1;
                if (gcnt_q == GapLast) begin
                    gcnt_d = '0;
                    if (hvalid_q) begin
                        sreg_d   = hbuf_q;
                        hvalid_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = StShift;
                    end else if (accept) begin
                        sreg_d  = din;
                        cnt_d   = '0;
                        state_d = StShift;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (accept) begin
                    hbuf_d   = din;
                    hvalid_d = 1'b1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= StIdle;
            sreg_q   <= '0;
            cnt_q    <= '0;
            gcnt_q   <= '0;
            hbuf_q   <= '0;
            hvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
            hbuf_q   <= hbuf_d;
            hvalid_q <= hvalid_d;
        end
    end

endmodule
